// File: rtl/enh_muldiv_unit.sv
// Iterative 32x32 multiply/divide engine: radix-2 shift-add multiply and
// restoring divide over 32 iterations, with sign fix-up and a 64-bit HI/LO result.
module enh_muldiv_unit (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic [1:0]  OP,
    input  logic [63:0] LONG_IN,
    output logic        BUSY,
    output logic        DONE,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        DZ
);

    localparam int unsigned W  = 32;
    localparam int unsigned DW = 64;
    localparam int unsigned CW = 6;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PREP = 3'd1;
    localparam logic [2:0] S_CALC = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [1:0]    op_q, op_d;
    logic [W-1:0]  s_q, s_d;
    logic [W-1:0]  t_q, t_d;
    logic [W-1:0]  b_q, b_d;
    logic [DW-1:0] acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          neg_q, neg_d;
    logic          negr_q, negr_d;
    logic [W-1:0]  hi_q, hi_d;
    logic [W-1:0]  lo_q, lo_d;
    logic          dz_q, dz_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [W-1:0]  abs_s, abs_t;
    logic [W:0]    mul_sum;
    logic [W:0]    div_rem;
    logic          div_ge;
    logic [W-1:0]  div_sub;
    logic [DW-1:0] mul_neg;
    logic [W-1:0]  quo_neg, rem_neg;

    // Datapath helpers shared by PREP, CALC and FIX
    always_comb begin
        abs_s   = (op_q[0] && s_q[W-1]) ? W'(0) - s_q : s_q;
        abs_t   = (op_q[0] && t_q[W-1]) ? W'(0) - t_q : t_q;
        mul_sum = {1'b0, acc_q[DW-1:W]} + {1'b0, b_q};
        div_rem = acc_q[DW-1:W-1];
        div_ge  = (div_rem >= {1'b0, b_q});
        div_sub = W'(div_rem - {1'b0, b_q});
        mul_neg = DW'(0) - acc_q;
        quo_neg = W'(0) - acc_q[W-1:0];
        rem_neg = W'(0) - acc_q[DW-1:W];
    end

    // Next-state and result logic
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        s_d     = s_q;
        t_d     = t_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        negr_d  = negr_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dz_d    = dz_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (START) begin
                    op_d    = OP;
                    s_d     = LONG_IN[DW-1:W];
                    t_d     = LONG_IN[W-1:0];
                    state_d = S_PREP;
                end
            end
            S_PREP: begin
                cnt_d  = '0;
                neg_d  = op_q[0] & (s_q[W-1] ^ t_q[W-1]);
                negr_d = op_q[0] & s_q[W-1];
                if (op_q[1]) begin
                    if (t_q == '0) begin
                        hi_d    = s_q;
                        lo_d    = '1;
                        dz_d    = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        acc_d   = {{W{1'b0}}, abs_s};
                        b_d     = abs_t;
                        state_d = S_CALC;
                    end
                end else begin
                    acc_d   = {{W{1'b0}}, abs_t};
                    b_d     = abs_s;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                cnt_d = cnt_q + CW'(1);
                if (op_q[1]) begin
                    // Remainder is 33 bits wide after the shift; quotient bit enters at LSB
                    acc_d = div_ge ? {div_sub, acc_q[W-2:0], 1'b1}
                                   : {div_rem[W-1:0], acc_q[W-2:0], 1'b0};
                end else begin
                    acc_d = acc_q[0] ? {mul_sum, acc_q[W-1:1]}
                                     : {1'b0, acc_q[DW-1:1]};
                end
                if (cnt_q == CW'(31)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (op_q[1]) begin
                    lo_d = neg_q  ? quo_neg : acc_q[W-1:0];
                    hi_d = negr_q ? rem_neg : acc_q[DW-1:W];
                end else begin
                    {hi_d, lo_d} = neg_q ? mul_neg : acc_q;
                end
                dz_d    = 1'b0;
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_PREP) || (state_d == S_CALC) || (state_d == S_FIX);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            s_q     <= '0;
            t_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            negr_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            s_q     <= s_d;
            t_q     <= t_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            negr_q  <= negr_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dz_q    <= dz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign BUSY = busy_q;
    assign DONE = done_q;
    assign HI   = hi_q;
    assign LO   = lo_q;
    assign DZ   = dz_q;

endmodule

// File: tb/tb_enh_muldiv_unit.sv
// Randomized self-checking bench for enh_muldiv_unit against an arithmetic reference model.
module tb_enh_muldiv_unit;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        START;
    logic [1:0]  OP;
    logic [63:0] LONG_IN;
    logic        BUSY;
    logic        DONE;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        DZ;

    int checks = 0;
    int errors = 0;

    enh_muldiv_unit dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .START   (START),
        .OP      (OP),
        .LONG_IN (LONG_IN),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .HI      (HI),
        .LO      (LO),
        .DZ      (DZ)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Returns {dz, hi, lo} using native 64-bit integer arithmetic
    function automatic logic [64:0] model(input logic [1:0] op, input logic [31:0] s,
                                          input logic [31:0] t);
        longint     ss, tt, q, r;
        logic [63:0] p;
        ss = longint'($signed(s));
        tt = longint'($signed(t));
        case (op)
            2'b00: begin
                p = 64'(s) * 64'(t);
                return {1'b0, p};
            end
            2'b01: begin
                p = 64'(ss * tt);
                return {1'b0, p};
            end
            2'b10: begin
                if (t == 32'd0) return {1'b1, s, 32'hFFFFFFFF};
                return {1'b0, s % t, s / t};
            end
            default: begin
                if (t == 32'd0) return {1'b1, s, 32'hFFFFFFFF};
                q = ss / tt;
                r = ss % tt;
                return {1'b0, 32'(r), 32'(q)};
            end
        endcase
    endfunction

    // Called at a negedge; returns at the negedge on which DONE is seen
    task automatic do_op(input logic [1:0] op, input logic [31:0] s, input logic [31:0] t,
                         input int inject);
        logic [64:0] e;
        int          cyc;
        int          lat;
        e   = model(op, s, t);
        lat = (op[1] && t == 32'd0) ? 2 : 35;
        START   = 1'b1;
        OP      = op;
        LONG_IN = {s, t};
        @(negedge CLK);
        START   = 1'b0;
        OP      = 2'($urandom);
        LONG_IN = {$urandom, $urandom};
        cyc = 1;
        while (!DONE && cyc < 80) begin
            check("busy_while_running", 64'(BUSY), 64'd1);
            START = (cyc == inject);
            if (cyc == inject) begin
                OP      = 2'($urandom);
                LONG_IN = {$urandom, $urandom};
            end
            @(negedge CLK);
            cyc++;
        end
        START = 1'b0;
        check("latency", 64'(cyc), 64'(lat));
        check("busy_at_done", 64'(BUSY), 64'd0);
        check("hi", 64'(HI), 64'(e[63:32]));
        check("lo", 64'(LO), 64'(e[31:0]));
        check("dz", 64'(DZ), 64'(e[64]));
    endtask

    task automatic idle(input int n);
        @(negedge CLK);
        check("done_single_pulse", 64'(DONE), 64'd0);
        repeat (n) @(negedge CLK);
    endtask

    initial begin
        int          seen;
        logic [1:0]  op;
        logic [31:0] s, t;

        RESET   = 1'b0;
        START   = 1'b0;
        OP      = 2'b00;
        LONG_IN = 64'd0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        check("rst_hi", 64'(HI), 64'd0);
        check("rst_lo", 64'(LO), 64'd0);
        check("rst_busy", 64'(BUSY), 64'd0);
        check("rst_done", 64'(DONE), 64'd0);
        check("rst_dz", 64'(DZ), 64'd0);

        do_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        check("multu_max", {HI, LO}, 64'hFFFFFFFE_00000001);
        idle(2);

        do_op(2'b01, 32'hFFFFFFFD, 32'd7, 0);
        check("mult_neg3x7", {HI, LO}, 64'hFFFFFFFF_FFFFFFEB);
        do_op(2'b11, 32'hFFFFFFF9, 32'd2, 0);
        check("div_neg7_2", {HI, LO}, 64'hFFFFFFFF_FFFFFFFD);
        idle(1);

        do_op(2'b10, 32'd100, 32'd0, 0);
        check("divu_by_zero", {31'd0, DZ, HI, LO}, {31'd0, 1'b1, 64'h00000064_FFFFFFFF});
        idle(1);
        do_op(2'b00, 32'd2, 32'd3, 0);
        check("dz_cleared", {31'd0, DZ, LO}, {31'd0, 1'b0, 32'd6});
        idle(1);

        do_op(2'b00, 32'h12345678, 32'h9ABCDEF0, 10);
        idle(1);

        do_op(2'b11, 32'h80000000, 32'hFFFFFFFF, 0);
        check("div_min_by_neg1", {HI, LO}, 64'h00000000_80000000);
        idle(1);
        do_op(2'b01, 32'h80000000, 32'h80000000, 0);
        check("mult_min_sq", {HI, LO}, 64'h40000000_00000000);
        idle(1);
        do_op(2'b11, 32'd7, 32'hFFFFFFFE, 0);
        check("div_7_neg2", {HI, LO}, 64'h00000001_FFFFFFFD);
        idle(1);

        // Abort an operation around iteration 10 and confirm it never completes
        START   = 1'b1;
        OP      = 2'b01;
        LONG_IN = {32'h0BADF00D, 32'h00C0FFEE};
        @(negedge CLK);
        START = 1'b0;
        repeat (11) @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
        check("abort_hi", 64'(HI), 64'd0);
        check("abort_lo", 64'(LO), 64'd0);
        check("abort_busy", 64'(BUSY), 64'd0);
        check("abort_done", 64'(DONE), 64'd0);
        check("abort_dz", 64'(DZ), 64'd0);
        seen = 0;
        repeat (60) begin
            @(negedge CLK);
            if (DONE) seen++;
        end
        check("no_done_after_abort", 64'(seen), 64'd0);

        for (int i = 0; i < 60; i++) begin
            op = 2'($urandom_range(0, 3));
            s  = $urandom;
            t  = $urandom;
            case ($urandom_range(0, 7))
                0: t = 32'd0;
                1: s = 32'h80000000;
                2: t = 32'hFFFFFFFF;
                3: t = 32'($urandom_range(1, 15));
                default: ;
            endcase
            do_op(op, s, t, ($urandom_range(0, 3) == 0) ? 3 : 0);
            if ($urandom_range(0, 1) == 0) idle($urandom_range(0, 3));
        end
        idle(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
